instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage of the RV32I core: owns the PC, issues word reads to instruction memory and presents one fetched instruction per handshake to decode, which drives the immediate sign-extender, control unit and register file. Handles variable memory latency, decode back-pressure and branch/jump redirects, and squashes stale responses. Replaces the bare PC register plus combinational ROM read path.

Parameters:
D_WIDTH, 32, instruction/data width
A_WIDTH, 32, PC/address width
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset; rst==0 at a rising edge resets the block
imem_req  out  1  read request valid
imem_addr  out  A_WIDTH  word-aligned read address
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  D_WIDTH  read data
redirect_en  in  1  taken branch/jal/jalr, single-cycle pulse
redirect_pc  in  A_WIDTH  redirect target
instr_valid  out  1  instr/instr_pc valid to decode
instr_ready  in  1  decode accepts instruction
instr  out  D_WIDTH  fetched instruction
instr_pc  out  A_WIDTH  PC of instr
instr_pc_plus4  out  A_WIDTH  instr_pc + 4, for jal/jalr link

Behaviour:
- Reset: pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr=0, instr_pc=0, instr_pc_plus4=0, drop flag=0. Reset mid-transaction abandons it; a later imem_rvalid with drop=0 and state IDLE is ignored.
- At most one outstanding memory read. Memory returns in order, at least 1 cycle after acceptance.
- States: IDLE -> REQ (first cycle after reset release). REQ: imem_req=1, imem_addr=pc; on imem_ready -> WAIT. WAIT: on imem_rvalid, capture imem_rdata/pc into output register, instr_valid=1, pc<=pc+4, -> HOLD. HOLD: instr_valid held, outputs stable; on instr_valid&&instr_ready drop instr_valid and -> REQ same edge (no prefetch; best throughput 1 instr per 3 cycles with 1-cycle memory).
- imem_req must not drop, and imem_addr must not change, until imem_ready, except on redirect.
- Redirect (highest priority, any state): pc<=redirect_pc; instr_valid<=0 (held instruction squashed even if instr_ready same cycle); REQ->REQ with new address next cycle; WAIT with no rvalid this cycle -> DROP; WAIT with rvalid same cycle -> discard data, -> REQ; HOLD -> REQ.
- DROP: wait for imem_rvalid, discard data, -> REQ. A second redirect in DROP only updates pc.
- PC arithmetic modulo 2^A_WIDTH; 32'hFFFF_FFFC+4 wraps to 0. redirect_pc[1:0] forced to 2'b00 (low bits ignored).
- Outputs registered; no combinational path from redirect_en/imem_rvalid to instr*.

Optional Feature:
IFU_MISALIGN_TRAP_EN: adds output fetch_misaligned (1 bit, reset 0). When defined, redirect with redirect_pc[1:0]!=0 sets fetch_misaligned (sticky until reset), enters HALT state: no further requests, instr_valid=0. Without macro: port absent, low bits silently cleared as above.

Decomposition:
- Package ifu_pkg: state enum (IDLE, REQ, WAIT, DROP, HOLD, HALT), RESET_PC default, PC_STEP=4 constant.
- Sub-module ifu_out_reg: instruction/PC output register with valid/ready hold and squash; FSM and PC stay in the top.

Test Plan:
- Reset release, imem_ready=1, 1-cycle rvalid, rdata=32'h00500093, instr_ready=1 -> first imem_addr=0; instr=32'h00500093, instr_pc=0, instr_pc_plus4=4; next request addr 4.
- Hold instr_ready=0 for 5 cycles after instr_valid -> instr/instr_pc stable, imem_req=0; accept -> next request addr 4.
- imem_ready=0 for 3 cycles -> imem_req=1, imem_addr constant throughout.
- redirect_en with redirect_pc=32'h40 in WAIT, rvalid 2 cycles later with rdata=32'hDEADBEEF -> data never appears on instr; next request addr 32'h40.
- redirect_en in HOLD with instr_ready=1 same cycle -> instruction not consumed (instr_valid low next cycle), next request addr redirect_pc.
- redirect_pc=32'hFFFF_FFFC -> fetch there, following request addr 0; with IFU_MISALIGN_TRAP_EN, redirect_pc=32'h42 -> fetch_misaligned=1, imem_req stays 0.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared state encoding and constants for the instruction fetch unit.
package ifu_pkg;

    // Fetch sequencer states. HALT is only reachable when IFU_MISALIGN_TRAP_EN is defined.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DROP = 3'd3,
        HOLD = 3'd4,
        HALT = 3'd5
    } ifu_state_t;

    // Default PC loaded on reset.
    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

    // Byte distance between consecutive RV32I instructions.
    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/ifu_out_reg.sv
// ifu_out_reg: instruction/PC output register towards decode.
// Loads a fetched word, holds it stable until decode accepts it,
// and can be squashed by a redirect (squash wins over ready and load).
module ifu_out_reg
    import ifu_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               squash,
    input  logic [D_WIDTH-1:0] load_instr,
    input  logic [A_WIDTH-1:0] load_pc,
    input  logic               ready,
    output logic               valid,
    output logic [D_WIDTH-1:0] instr,
    output logic [A_WIDTH-1:0] pc,
    output logic [A_WIDTH-1:0] pc_plus4
);

    // Output register: capture on load, drop valid on handshake or squash.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid    <= 1'b0;
            instr    <= '0;
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (squash) begin
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= load_instr;
            pc       <= load_pc;
            pc_plus4 <= load_pc + A_WIDTH'(PC_STEP);
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage. Owns the PC, issues one word read at a
// time to instruction memory and presents each fetched instruction to decode
// with a valid/ready handshake. Redirects squash the held instruction and any
// in-flight read. Reset is synchronous, active low (rst==0 at a rising edge).
// Optional build macro IFU_MISALIGN_TRAP_EN: a redirect to a non word-aligned
// target raises the sticky fetch_misaligned output and halts fetching.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int               D_WIDTH  = 32,
    parameter int               A_WIDTH  = 32,
    parameter logic [A_WIDTH-1:0] RESET_PC = A_WIDTH'(IFU_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [D_WIDTH-1:0] imem_rdata,
    input  logic               redirect_en,
    input  logic [A_WIDTH-1:0] redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [D_WIDTH-1:0] instr,
    output logic [A_WIDTH-1:0] instr_pc,
    output logic [A_WIDTH-1:0] instr_pc_plus4
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    output logic               fetch_misaligned
`endif
);

    ifu_state_t         state, state_nxt;
    logic [A_WIDTH-1:0] pc, pc_nxt;
    logic [A_WIDTH-1:0] redirect_target;
    logic               out_load;
    logic               out_squash;

    // Instruction addresses are word aligned; the low target bits are ignored.
    assign redirect_target = {redirect_pc[A_WIDTH-1:2], 2'b00};

    // The request is a decode of the state register and the address is the PC
    // register, so both stay stable for as long as the sequencer sits in REQ.
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

`ifdef IFU_MISALIGN_TRAP_EN
    logic misalign_set;
`else
    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc[1:0];
`endif

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Next-state, next-PC and output-register control; redirect overrides all.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_nxt  = state;
        pc_nxt     = pc;
        out_load   = 1'b0;
        out_squash = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
        misalign_set = 1'b0;
`endif

        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (imem_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    out_load  = 1'b1;
                    pc_nxt    = pc + A_WIDTH'(PC_STEP);
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // No prefetch: the next read is only issued once decode takes this one.
                if (instr_valid && instr_ready) state_nxt = REQ;
            end
            DROP: begin
                if (imem_rvalid) state_nxt = REQ;
            end
            HALT: state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase

        if (redirect_en && (state != HALT)) begin
            pc_nxt     = redirect_target;
            out_load   = 1'b0;
            out_squash = 1'b1;
            case (state)
                // A read accepted in the redirect cycle still returns data, so it
                // must be drained before the new address can be requested.
                REQ:     state_nxt = imem_ready  ? DROP : REQ;
                WAIT:    state_nxt = imem_rvalid ? REQ  : DROP;
                DROP:    state_nxt = imem_rvalid ? REQ  : DROP;
                default: state_nxt = REQ;
            endcase
`ifdef IFU_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_nxt    = HALT;
                misalign_set = 1'b1;
            end
`endif
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    // Sticky misaligned-fetch flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_misaligned <= 1'b0;
        end else if (misalign_set) begin
            fetch_misaligned <= 1'b1;
        end
    end
`endif

    ifu_out_reg #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (out_load),
        .squash     (out_squash),
        .load_instr (imem_rdata),
        .load_pc    (pc),
        .ready      (instr_ready),
        .valid      (instr_valid),
        .instr      (instr),
        .pc         (instr_pc),
        .pc_plus4   (instr_pc_plus4)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit. Stimulus pushes
// expected request addresses and expected decode handshakes into queues; a
// monitor pops and compares them whenever the DUT presents them.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
`ifdef IFU_MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t        ins_q[$];
    logic [31:0] req_q[$];
    int          total = 0;
    int          bad   = 0;

    bit          mem_ready_en = 1'b1;
    int          lat          = 1;
    bit          poison       = 1'b0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
`ifdef IFU_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            32'h0000_0008: return 32'h00F0_0193;
            32'h0000_0040: return 32'h0140_0213;
            32'h0000_0044: return 32'h0190_0293;
            32'hFFFF_FFFC: return 32'h0000_006F;
            default:       return 32'h0000_0013;
        endcase
    endfunction

    // Instruction memory model: acceptance decided at the falling edge, data
    // returned lat cycles after the accepting rising edge.
    initial begin
        bit          pending;
        int          cnt;
        logic [31:0] paddr;
        pending     = 1'b0;
        cnt         = 0;
        paddr       = '0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = poison ? 32'hDEAD_BEEF : mem_word(paddr);
                    poison      = 1'b0;
                    pending     = 1'b0;
                end
            end
            imem_ready = mem_ready_en;
            if (imem_req === 1'b1 && imem_ready) begin
                check("one_outstanding", 32'(pending), 32'd0);
                pending = 1'b1;
                cnt     = lat;
                paddr   = imem_addr;
            end
        end
    end

    // Monitor: compares accepted requests and decode handshakes against the queues.
    initial begin
        bit          prev_stall;
        logic [31:0] prev_addr;
        exp_t        e;
        logic [31:0] a;
        prev_stall = 1'b0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            #3;
            if (prev_stall) begin
                check("req_held", 32'(imem_req), 32'd1);
                check("addr_held", imem_addr, prev_addr);
            end
            prev_stall = (rst === 1'b1) && (imem_req === 1'b1) && !imem_ready && !redirect_en;
            prev_addr  = imem_addr;
            if (imem_req === 1'b1 && imem_ready) begin
                if (req_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL req_unexpected: addr %h, none expected", imem_addr);
                end else begin
                    a = req_q.pop_front();
                    check("req_addr", imem_addr, a);
                end
            end
            if (instr_valid === 1'b1 && instr_ready && !redirect_en) begin
                if (ins_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ins_unexpected: instr %h pc %h, none expected", instr, instr_pc);
                end else begin
                    e = ins_q.pop_front();
                    check("ins_word", instr, e.instr);
                    check("ins_pc", instr_pc, e.pc);
                    check("ins_pc4", instr_pc_plus4, e.pc4);
                end
            end
        end
    end

    task automatic push_ins(input logic [31:0] w, input logic [31:0] p, input logic [31:0] p4);
        exp_t e;
        e.instr = w;
        e.pc    = p;
        e.pc4   = p4;
        ins_q.push_back(e);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (instr_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(instr_valid), 32'd1);
    endtask

    task automatic accept_one();
        @(negedge clk);
        #1;
        instr_ready = 1'b1;
        @(negedge clk);
        #1;
        instr_ready = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] tgt, input logic rdy);
        redirect_en = 1'b1;
        redirect_pc = tgt;
        instr_ready = rdy;
        @(negedge clk);
        #1;
        redirect_en = 1'b0;
        instr_ready = 1'b0;
    endtask

    // Directed stimulus.
    initial begin
        int n;
        rst         = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_pc4", instr_pc_plus4, 32'd0);
`ifdef IFU_MISALIGN_TRAP_EN
        check("rst_misaligned", 32'(fetch_misaligned), 32'd0);
`endif

        // First fetch from RESET_PC, held 5 cycles under back-pressure.
        req_q.push_back(32'h0000_0000);
        push_ins(32'h0050_0093, 32'h0000_0000, 32'h0000_0004);
        req_q.push_back(32'h0000_0004);
        rst = 1'b1;
        wait_valid("valid_first");
        repeat (5) begin
            check("hold_instr", instr, 32'h0050_0093);
            check("hold_pc", instr_pc, 32'h0000_0000);
            check("hold_no_req", 32'(imem_req), 32'd0);
            check("hold_valid", 32'(instr_valid), 32'd1);
            @(negedge clk);
            #1;
        end
        accept_one();

        // Memory not ready for 3 cycles: request and address must hold.
        wait_valid("valid_4");
        push_ins(32'h00A0_0113, 32'h0000_0004, 32'h0000_0008);
        req_q.push_back(32'h0000_0008);
        mem_ready_en = 1'b0;
        @(negedge clk);
        #1;
        accept_one();
        repeat (3) begin
            check("stall_req", 32'(imem_req), 32'd1);
            check("stall_addr", imem_addr, 32'h0000_0008);
            @(negedge clk);
            #1;
        end
        mem_ready_en = 1'b1;

        // Redirect while waiting; the late response (DEADBEEF) must be discarded.
        wait_valid("valid_8");
        push_ins(32'h00F0_0193, 32'h0000_0008, 32'h0000_000C);
        req_q.push_back(32'h0000_000C);
        req_q.push_back(32'h0000_0040);
        lat    = 3;
        poison = 1'b1;
        accept_one();
        @(negedge clk);
        #1;
        do_redirect(32'h0000_0040, 1'b0);
        lat = 1;
        wait_valid("valid_40");
        check("after_drop_instr", instr, 32'h0140_0213);
        push_ins(32'h0140_0213, 32'h0000_0040, 32'h0000_0044);
        req_q.push_back(32'h0000_0044);
        accept_one();

        // Redirect in HOLD with instr_ready high: the held instruction is squashed.
        wait_valid("valid_44");
        check("held_44", instr, 32'h0190_0293);
        req_q.push_back(32'hFFFF_FFFC);
        do_redirect(32'hFFFF_FFFC, 1'b1);
        check("squash_valid", 32'(instr_valid), 32'd0);

        // Top-of-memory fetch and PC wrap to zero.
        wait_valid("valid_top");
        push_ins(32'h0000_006F, 32'hFFFF_FFFC, 32'h0000_0000);
        req_q.push_back(32'h0000_0000);
        accept_one();
        wait_valid("valid_wrap");
        push_ins(32'h0050_0093, 32'h0000_0000, 32'h0000_0004);
        req_q.push_back(32'h0000_0004);
        accept_one();
        wait_valid("valid_4b");

        // Redirect with non-zero low target bits.
`ifdef IFU_MISALIGN_TRAP_EN
        do_redirect(32'h0000_0042, 1'b0);
        check("misaligned_set", 32'(fetch_misaligned), 32'd1);
        repeat (4) begin
            check("halt_no_req", 32'(imem_req), 32'd0);
            check("halt_no_valid", 32'(instr_valid), 32'd0);
            @(negedge clk);
            #1;
        end
`else
        req_q.push_back(32'h0000_0040);
        do_redirect(32'h0000_0042, 1'b0);
        wait_valid("valid_align");
        push_ins(32'h0140_0213, 32'h0000_0040, 32'h0000_0044);
        req_q.push_back(32'h0000_0044);
        accept_one();
`endif

        n = 0;
        while ((req_q.size() != 0 || ins_q.size() != 0) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_req", 32'(req_q.size()), 32'd0);
        check("drain_ins", 32'(ins_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
